clk_gate_idle_ctrl: RTL and testbench

- Generates the `local_en` term for a unit's `gated_clk_cell` instance.
- Counts consecutive idle cycles. After a programmable threshold it drops `local_en`, so the unit's clock gates off.
- On a wake request or new activity it restores `local_en`. It then holds the unit not-ready for a fixed settle window before reporting the clock usable.
- Runs on the ungated clock and sits directly upstream of the gated clock cell.

---
 rtl/clk_gate_idle_ctrl.sv | 97 +++++++++
 tb/tb_clk_gate_idle_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_gate_idle_ctrl.sv
// Idle-driven clock-gate controller: produces local_en for the unit's gated clock
// cell, gating after a programmable idle run and re-enabling with a fixed settle window.
module clk_gate_idle_ctrl #(
    parameter int unsigned CNT_W    = 5,
    parameter int unsigned WAKE_DLY = 2
) (
    input  logic             forever_cpuclk,
    input  logic             cpurst_b,
    input  logic             ctrl_busy,
    input  logic             ctrl_wake_req,
    input  logic             cfg_gate_en,
    input  logic [CNT_W-1:0] cfg_idle_thresh,
    output logic             local_en,
    output logic             ctrl_ready,
    output logic [1:0]       gate_state
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_GATED = 2'b10,
        ST_WAKE  = 2'b11
    } state_t;

    localparam logic [3:0] WAKE_LAST = 4'(WAKE_DLY - 1);

    state_t           state;
    logic [CNT_W-1:0] idle_cnt;
    logic [3:0]       wake_cnt;

    logic             idle;
    logic             wake_evt;
    logic             thresh_hit;
    logic [CNT_W:0]   idle_cnt_inc;

    always_comb begin
        idle         = cfg_gate_en & ~ctrl_busy & ~ctrl_wake_req & (cfg_idle_thresh != '0);
        wake_evt     = ctrl_wake_req | ctrl_busy | ~cfg_gate_en;
        // One extra bit so the +1 compare cannot wrap when idle_cnt is saturated.
        idle_cnt_inc = {1'b0, idle_cnt} + {{CNT_W{1'b0}}, 1'b1};
        thresh_hit   = idle_cnt_inc >= {1'b0, cfg_idle_thresh};
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state      <= ST_RUN;
            local_en   <= 1'b1;
            ctrl_ready <= 1'b1;
            idle_cnt   <= '0;
            wake_cnt   <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    wake_cnt <= '0;
                    if (!idle) begin
                        idle_cnt <= '0;
                    end else if (thresh_hit) begin
                        state      <= ST_GATED;
                        local_en   <= 1'b0;
                        ctrl_ready <= 1'b0;
                        idle_cnt   <= '0;
                    end else if (idle_cnt != '1) begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                ST_GATED: begin
                    idle_cnt <= '0;
                    if (wake_evt) begin
                        state    <= ST_WAKE;
                        local_en <= 1'b1;
                        wake_cnt <= '0;
                    end
                end
                ST_WAKE: begin
                    // Inputs are deliberately ignored here: no re-gating during settle.
                    idle_cnt <= '0;
                    if (wake_cnt == WAKE_LAST) begin
                        state      <= ST_RUN;
                        ctrl_ready <= 1'b1;
                        wake_cnt   <= '0;
                    end else begin
                        wake_cnt <= wake_cnt + 1'b1;
                    end
                end
                default: begin
                    state      <= ST_RUN;
                    local_en   <= 1'b1;
                    ctrl_ready <= 1'b1;
                    idle_cnt   <= '0;
                    wake_cnt   <= '0;
                end
            endcase
        end
    end

    assign gate_state = state;

endmodule

// File: tb/tb_clk_gate_idle_ctrl.sv
// Directed self-checking bench for clk_gate_idle_ctrl (CNT_W=5, WAKE_DLY=2).
module tb_clk_gate_idle_ctrl;

    logic       clk;
    logic       rst_b;
    logic       busy;
    logic       wake;
    logic       gate_en;
    logic [4:0] thresh;
    logic       local_en;
    logic       ready;
    logic [1:0] gs;

    int checks = 0;
    int errors = 0;

    clk_gate_idle_ctrl #(.CNT_W(5), .WAKE_DLY(2)) dut (
        .forever_cpuclk  (clk),
        .cpurst_b        (rst_b),
        .ctrl_busy       (busy),
        .ctrl_wake_req   (wake),
        .cfg_gate_en     (gate_en),
        .cfg_idle_thresh (thresh),
        .local_en        (local_en),
        .ctrl_ready      (ready),
        .gate_state      (gs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        busy    = 1'b0;
        wake    = 1'b0;
        gate_en = 1'b1;
        thresh  = 5'd4;
        rst_b   = 1'b0;
        #2;
        rst_b   = 1'b1;
    endtask

    task automatic test_reset();
        busy = 1'b0; wake = 1'b0; gate_en = 1'b1; thresh = 5'd4;
        rst_b = 1'b0;
        #3;
        checks++;
        if ({local_en, ready, gs} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_vals got %b exp 1100", {local_en, ready, gs});
        end
        step();
        checks++;
        if ({local_en, ready, gs} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_held got %b exp 1100", {local_en, ready, gs});
        end
        rst_b = 1'b1;
    endtask

    task automatic test_gate_thresh();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++;
            if (i < 4 && {local_en, ready, gs} !== 4'b1100) begin
                errors++;
                $display("FAIL gate_pre edge %0d got %b exp 1100", i, {local_en, ready, gs});
            end else if (i == 4 && {local_en, ready, gs} !== 4'b0010) begin
                errors++;
                $display("FAIL gate_hit got %b exp 0010", {local_en, ready, gs});
            end
        end
        step();
        checks++;
        if ({local_en, ready, gs} !== 4'b0010) begin
            errors++;
            $display("FAIL gate_stay got %b exp 0010", {local_en, ready, gs});
        end
    endtask

    task automatic test_busy_restart();
        do_reset();
        repeat (3) step();
        busy = 1'b1;
        step();
        busy = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++;
            if (i < 4 && gs !== 2'b00) begin
                errors++;
                $display("FAIL busy_restart edge %0d gs got %b exp 00", i, gs);
            end else if (i == 4 && {local_en, ready, gs} !== 4'b0010) begin
                errors++;
                $display("FAIL busy_restart_gate got %b exp 0010", {local_en, ready, gs});
            end
        end
    endtask

    task automatic test_wake_latency();
        do_reset();
        repeat (4) step();
        wake = 1'b1;
        step();
        wake = 1'b0;
        checks++;
        if ({local_en, ready, gs} !== 4'b1011) begin
            errors++;
            $display("FAIL wake_e1 got %b exp 1011", {local_en, ready, gs});
        end
        step();
        checks++;
        if ({local_en, ready, gs} !== 4'b1011) begin
            errors++;
            $display("FAIL wake_e2 got %b exp 1011", {local_en, ready, gs});
        end
        step();
        checks++;
        if ({local_en, ready, gs} !== 4'b1100) begin
            errors++;
            $display("FAIL wake_e3 got %b exp 1100", {local_en, ready, gs});
        end
    endtask

    task automatic test_no_gate();
        int bad;
        do_reset();
        thresh = 5'd0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (local_en !== 1'b1 || ready !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL thresh0_on bad_cycles %0d exp 0", bad);
        end
        thresh  = 5'd4;
        gate_en = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (local_en !== 1'b1 || ready !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL gate_dis_on bad_cycles %0d exp 0", bad);
        end
        // Gate, then drop cfg_gate_en while gated.
        gate_en = 1'b1;
        repeat (4) step();
        checks++;
        if (gs !== 2'b10) begin
            errors++;
            $display("FAIL gate_en_pre gs got %b exp 10", gs);
        end
        gate_en = 1'b0;
        step();
        checks++;
        if ({local_en, ready, gs} !== 4'b1011) begin
            errors++;
            $display("FAIL gate_en_wake1 got %b exp 1011", {local_en, ready, gs});
        end
        step();
        checks++;
        if (gs !== 2'b11) begin
            errors++;
            $display("FAIL gate_en_wake2 gs got %b exp 11", gs);
        end
        step();
        checks++;
        if ({local_en, ready, gs} !== 4'b1100) begin
            errors++;
            $display("FAIL gate_en_run got %b exp 1100", {local_en, ready, gs});
        end
    endtask

    task automatic test_async_reset();
        // Mid-WAKE
        do_reset();
        repeat (4) step();
        wake = 1'b1;
        step();
        wake = 1'b0;
        #2;
        rst_b = 1'b0;
        #1;
        checks++;
        if ({local_en, ready, gs} !== 4'b1100) begin
            errors++;
            $display("FAIL rst_mid_wake got %b exp 1100", {local_en, ready, gs});
        end
        rst_b = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++;
            if (i < 4 && gs !== 2'b00) begin
                errors++;
                $display("FAIL rst_wake_recount edge %0d gs got %b exp 00", i, gs);
            end else if (i == 4 && gs !== 2'b10) begin
                errors++;
                $display("FAIL rst_wake_regate gs got %b exp 10", gs);
            end
        end
        // Mid-GATED
        #2;
        rst_b = 1'b0;
        #1;
        checks++;
        if ({local_en, ready, gs} !== 4'b1100) begin
            errors++;
            $display("FAIL rst_mid_gated got %b exp 1100", {local_en, ready, gs});
        end
        rst_b = 1'b1;
        repeat (3) step();
        checks++;
        if (gs !== 2'b00) begin
            errors++;
            $display("FAIL rst_gated_recount gs got %b exp 00", gs);
        end
        step();
        checks++;
        if (gs !== 2'b10) begin
            errors++;
            $display("FAIL rst_gated_regate gs got %b exp 10", gs);
        end
    endtask

    task automatic test_thresh_live();
        do_reset();
        thresh = 5'd16;
        repeat (10) step();
        checks++;
        if (gs !== 2'b00) begin
            errors++;
            $display("FAIL live_pre gs got %b exp 00", gs);
        end
        thresh = 5'd5;
        step();
        checks++;
        if ({local_en, ready, gs} !== 4'b0010) begin
            errors++;
            $display("FAIL live_lower got %b exp 0010", {local_en, ready, gs});
        end
    endtask

    task automatic test_simultaneous();
        // Gate enable falls on the edge that would reach the threshold.
        do_reset();
        repeat (3) step();
        gate_en = 1'b0;
        step();
        checks++;
        if ({local_en, ready, gs} !== 4'b1100) begin
            errors++;
            $display("FAIL gate_en_fall got %b exp 1100", {local_en, ready, gs});
        end
        // Busy during WAKE does not alter ready timing; wake+busy is one event.
        gate_en = 1'b1;
        repeat (4) step();
        wake = 1'b1;
        busy = 1'b1;
        step();
        wake = 1'b0;
        step();
        checks++;
        if ({local_en, ready, gs} !== 4'b1011) begin
            errors++;
            $display("FAIL busy_wake_e2 got %b exp 1011", {local_en, ready, gs});
        end
        step();
        checks++;
        if ({local_en, ready, gs} !== 4'b1100) begin
            errors++;
            $display("FAIL busy_wake_e3 got %b exp 1100", {local_en, ready, gs});
        end
        busy = 1'b0;
    endtask

    initial begin
        rst_b = 1'b1;
        busy = 1'b0; wake = 1'b0; gate_en = 1'b1; thresh = 5'd4;
        #2;
        test_reset();
        test_gate_thresh();
        test_busy_restart();
        test_wake_latency();
        test_no_gate();
        test_async_reset();
        test_thresh_live();
        test_simultaneous();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
